// File: rtl/adder_accum_stream.sv
// Streaming packet accumulator around a ripple-carry adder with carry-event counting.
// Optional macro ACCUM_SAT_EN: saturate the accumulator to all-ones on the first carry of a packet.

module adder_1bit #(
    parameter int IMPL_TYPE = 0
) (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    generate
        if (IMPL_TYPE == 0) begin : g_gate
            assign s    = a ^ b ^ cin;
            assign cout = (a & b) | (cin & (a ^ b));
        end else begin : g_arith
            assign {cout, s} = {1'b0, a} + {1'b0, b} + {1'b0, cin};
        end
    endgenerate
endmodule

module adder_nbit_cout #(
    parameter int WIDTH     = 32,
    parameter int IMPL_TYPE = 0
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = 1'b0;
    assign Cout       = w_carry[WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_fa (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (w_carry[gi]),
                .s    (Sum[gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate
endmodule

module adder_accum_stream #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8,
    parameter int IMPL_TYPE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic [CNT_WIDTH-1:0] out_carry_cnt,
    output logic                 out_ovf
);
    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     w_acc_next;
    logic [CNT_WIDTH-1:0] r_carry_cnt;
    logic [CNT_WIDTH-1:0] w_carry_cnt_next;
    logic                 r_ovf;
    logic                 w_ovf_next;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic                 w_accept;

    adder_nbit_cout #(.WIDTH(WIDTH), .IMPL_TYPE(IMPL_TYPE)) u_adder (
        .A    (r_acc),
        .B    (in_data),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    assign w_accept = in_valid & r_in_ready & (r_state == ST_ACC);

    // Next-state and datapath update: accumulate in ACC, hold or clear on handoff in DONE.
    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_carry_cnt_next = r_carry_cnt;
        w_ovf_next       = r_ovf;
        case (r_state)
            ST_ACC: begin
                if (w_accept) begin
`ifdef ACCUM_SAT_EN
                    w_acc_next = w_cout ? {WIDTH{1'b1}} : w_sum;
`else
                    w_acc_next = w_sum;
`endif
                    if (w_cout) begin
                        if (r_carry_cnt == {CNT_WIDTH{1'b1}}) begin
                            w_ovf_next = 1'b1;
                        end else begin
                            w_carry_cnt_next = r_carry_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        w_carry_cnt_next = r_carry_cnt;
                    end
                    if (in_last) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_ACC;
                    end
                end else begin
                    w_state_next = ST_ACC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_acc_next       = {WIDTH{1'b0}};
                    w_carry_cnt_next = {CNT_WIDTH{1'b0}};
                    w_ovf_next       = 1'b0;
                    w_state_next     = ST_ACC;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

    // State, datapath and handshake registers; ready/valid follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_acc       <= {WIDTH{1'b0}};
            r_carry_cnt <= {CNT_WIDTH{1'b0}};
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_carry_cnt <= w_carry_cnt_next;
            r_ovf       <= w_ovf_next;
            r_in_ready  <= (w_state_next == ST_ACC);
            r_out_valid <= (w_state_next == ST_DONE);
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_sum       = r_acc;
    assign out_carry_cnt = r_carry_cnt;
    assign out_ovf       = r_ovf;
endmodule

// File: tb/tb_adder_accum_stream.sv
// Randomized bench for adder_accum_stream (WIDTH=8, CNT_WIDTH=2) against an integer-sum reference model.
module tb_adder_accum_stream;
    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_carry_cnt;
    logic          out_ovf;

    int checks = 0;
    int failures = 0;
    logic [7:0] pkt[$];

    adder_accum_stream #(.WIDTH(W), .CNT_WIDTH(CW), .IMPL_TYPE(0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sum       (out_sum),
        .out_carry_cnt (out_carry_cnt),
        .out_ovf       (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer sum; every pass beyond 255 is one carry event.
    task automatic model(output logic [7:0] s, output logic [1:0] c, output logic o);
        int acc = 0;
        int cnt = 0;
        int ov  = 0;
        foreach (pkt[i]) begin
            acc = acc + int'(pkt[i]);
            if (acc > 255) begin
                acc = acc - 256;
                if (cnt == 3) ov = 1;
                else cnt = cnt + 1;
`ifdef ACCUM_SAT_EN
                acc = 255;
`endif
            end
        end
        s = acc[7:0];
        c = cnt[1:0];
        o = (ov != 0);
    endtask

    task automatic push_word(input logic [7:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_value("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_packet(input int bp);
        logic [7:0] es;
        logic [1:0] ec;
        logic       eo;
        model(es, ec, eo);
        out_ready = (bp == 0);
        foreach (pkt[i]) begin
            if ($urandom_range(0, 2) == 0) @(negedge clk);
            push_word(pkt[i], (i == pkt.size() - 1));
        end
        check_value("lat_valid", 32'(out_valid), 32'd1);
        check_value("done_ready", 32'(in_ready), 32'd0);
        check_value("sum", 32'(out_sum), 32'(es));
        check_value("carry_cnt", 32'(out_carry_cnt), 32'(ec));
        check_value("ovf", 32'(out_ovf), 32'(eo));
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            check_value("bp_valid", 32'(out_valid), 32'd1);
            check_value("bp_ready", 32'(in_ready), 32'd0);
            check_value("bp_sum", 32'(out_sum), 32'(es));
            check_value("bp_cnt", 32'(out_carry_cnt), 32'(ec));
            check_value("bp_ovf", 32'(out_ovf), 32'(eo));
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_value("handoff_valid", 32'(out_valid), 32'd0);
        check_value("handoff_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset for 3 cycles, then ready must rise on the first edge after release.
        repeat (3) begin
            @(negedge clk);
            check_value("rst_ready", 32'(in_ready), 32'd0);
            check_value("rst_valid", 32'(out_valid), 32'd0);
            check_value("rst_sum", 32'(out_sum), 32'd0);
            check_value("rst_cnt", 32'(out_carry_cnt), 32'd0);
            check_value("rst_ovf", 32'(out_ovf), 32'd0);
        end
        rst_n = 1'b1;
        #1;
        check_value("rel_ready_early", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_value("rel_ready", 32'(in_ready), 32'd1);

        pkt = '{8'h10, 8'h20, 8'h30};
        run_packet(0);
        pkt = '{8'hF0, 8'h20};
        run_packet(0);
        pkt = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_packet(0);
        pkt = '{8'h81, 8'h7F, 8'h01};
        run_packet(4);
        pkt = '{8'h33};
        run_packet(2);

        // Reset after 2 of 3 words: partial sum must vanish.
        push_word(8'hA0, 1'b0);
        push_word(8'h70, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_value("mid_rst_valid", 32'(out_valid), 32'd0);
        check_value("mid_rst_ready", 32'(in_ready), 32'd0);
        check_value("mid_rst_sum", 32'(out_sum), 32'd0);
        check_value("mid_rst_cnt", 32'(out_carry_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pkt = '{8'h05};
        run_packet(0);

        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 7);
            pkt.delete();
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 1) == 1) pkt.push_back(8'($urandom_range(128, 255)));
                else pkt.push_back(8'($urandom));
            end
            run_packet($urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
